led_blinker: RTL and testbench

LED_BLINKER -- requirements
Module: led_blinker

---
 rtl/led_pkg.sv | 19 +
 rtl/led_blinker_tick_gen.sv | 29 ++
 rtl/led_blinker.sv | 115 +++++++++++
 tb/tb_led_blinker.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared mode encoding and port-width helpers for the LED blinker.
package led_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    PWM   = 2'd3
  } led_mode_e;

  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int rate_width(input int ph_w);
    return (ph_w > 1) ? $clog2(ph_w) : 1;
  endfunction

endpackage

// File: rtl/led_blinker_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 48000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_blinker.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM with a shared phase tick
// and a one-write-per-two-cycles configuration port.
module led_blinker
  import led_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int TICK_DIV = 48000,
  parameter int PH_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_width(NCH)-1:0]    cfg_ch,
  input  logic [1:0]                  cfg_mode,
  input  logic [rate_width(PH_W)-1:0] cfg_rate,
  input  logic [PH_W-1:0]             cfg_duty,
  output logic                        cfg_err,
  output logic [NCH-1:0]              led
);

  localparam int CH_W   = ch_width(NCH);
  localparam int RATE_W = rate_width(PH_W);

  logic tick;
  logic cfg_accept;
  logic cfg_ready_q, cfg_ready_d;
  logic cfg_err_q, cfg_err_d;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign cfg_accept = cfg_valid && cfg_ready_q;
  assign cfg_ready  = cfg_ready_q;
  assign cfg_err    = cfg_err_q;

  // Ready drops for the cycle after each accepted write; out-of-range targets flag an error.
  always_comb begin
    cfg_ready_d = !cfg_accept;
    cfg_err_d   = cfg_accept && (int'(cfg_ch) >= NCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    led_mode_e         mode_q, mode_d;
    logic [RATE_W-1:0] rate_q, rate_d, rate_eff;
    logic [PH_W-1:0]   duty_q, duty_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              ch_wr;
    logic              led_q, led_d;

    assign ch_wr    = cfg_accept && (cfg_ch == CH_W'(i));
    assign rate_eff = (int'(rate_q) >= PH_W) ? RATE_W'(PH_W - 1) : rate_q;

    // A write restarts the phase even when it lands on a tick.
    always_comb begin
      mode_d  = mode_q;
      rate_d  = rate_q;
      duty_d  = duty_q;
      phase_d = phase_q;
      if (ch_wr) begin
        mode_d  = led_mode_e'(cfg_mode);
        rate_d  = cfg_rate;
        duty_d  = cfg_duty;
        phase_d = '0;
      end else if (tick) begin
        phase_d = phase_q + 1'b1;
      end
    end

    always_comb begin
      led_d = 1'b0;
      unique case (mode_q)
        OFF:     led_d = 1'b0;
        ON:      led_d = 1'b1;
        BLINK:   led_d = phase_q[rate_eff];
        PWM:     led_d = (phase_q < duty_q);
        default: led_d = 1'b0;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        mode_q  <= OFF;
        rate_q  <= '0;
        duty_q  <= '0;
        phase_q <= '0;
        led_q   <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        rate_q  <= rate_d;
        duty_q  <= duty_d;
        phase_q <= phase_d;
        led_q   <= led_d;
      end
    end

    assign led[i] = led_q;
  end

endmodule

// File: tb/tb_led_blinker.sv
// Scoreboard bench for led_blinker: a cycle model pushes expected outputs per driven
// cycle, and each scenario task pops and compares them alongside its own targeted checks.
module tb_led_blinker;
  import led_pkg::*;

  localparam int NCH      = 3;
  localparam int TICK_DIV = 4;
  localparam int PH_W     = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [1:0]     cfg_mode;
  logic [2:0]     cfg_rate;
  logic [7:0]     cfg_duty;
  logic           cfg_err;
  logic [NCH-1:0] led;

  led_blinker #(
    .NCH(NCH),
    .TICK_DIV(TICK_DIV),
    .PH_W(PH_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_rate (cfg_rate),
    .cfg_duty (cfg_duty),
    .cfg_err  (cfg_err),
    .led      (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] led;
    logic           ready;
    logic           err;
    logic           tick;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state, advanced once per driven cycle.
  int          m_cnt = 0;
  logic [7:0]  m_phase [NCH];
  logic [1:0]  m_mode  [NCH];
  logic [2:0]  m_rate  [NCH];
  logic [7:0]  m_duty  [NCH];
  logic [NCH-1:0] m_led = '0;
  logic        m_ready = 1'b0;
  logic        m_err   = 1'b0;

  task automatic applyStimulus(input logic rst, input logic v, input logic [1:0] ch,
                               input logic [1:0] mode, input logic [2:0] rate,
                               input logic [7:0] duty);
    exp_t e;
    logic acc, tk;
    logic [NCH-1:0] nled;
    reset     = rst;
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_rate  = rate;
    cfg_duty  = duty;
    nled      = '0;
    if (rst) begin
      m_cnt   = 0;
      m_led   = '0;
      m_ready = 1'b0;
      m_err   = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_phase[i] = '0;
        m_mode[i]  = 2'd0;
        m_rate[i]  = '0;
        m_duty[i]  = '0;
      end
    end else begin
      acc = v && m_ready;
      tk  = (m_cnt == TICK_DIV - 1);
      for (int i = 0; i < NCH; i++) begin
        case (m_mode[i])
          2'd0:    nled[i] = 1'b0;
          2'd1:    nled[i] = 1'b1;
          2'd2:    nled[i] = m_phase[i][m_rate[i]];
          default: nled[i] = (m_phase[i] < m_duty[i]);
        endcase
        if (acc && int'(ch) == i) begin
          m_mode[i]  = mode;
          m_rate[i]  = rate;
          m_duty[i]  = duty;
          m_phase[i] = '0;
        end else if (tk) begin
          m_phase[i] = m_phase[i] + 8'd1;
        end
      end
      m_led   = nled;
      m_cnt   = tk ? 0 : m_cnt + 1;
      m_err   = acc && (int'(ch) >= NCH);
      m_ready = !acc;
    end
    e.led   = m_led;
    e.ready = m_ready;
    e.err   = m_err;
    e.tick  = (m_cnt == TICK_DIV - 1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 23; k++) begin
      applyStimulus(k < 3, 1'b0, 2'd0, 2'd0, 3'd0, 8'd0);
      e = sb.pop_front();
      n_checks++;
      if ({led, cfg_ready, cfg_err, dut.u_tick.tick} !== e) begin
        n_fail++;
        $display("[TB] FAIL reset_sb cyc %0d: got led=%b rdy=%b err=%b tick=%b, want led=%b rdy=%b err=%b tick=%b",
                 cyc, led, cfg_ready, cfg_err, dut.u_tick.tick, e.led, e.ready, e.err, e.tick);
      end
      if (k < 3) begin
        n_checks++;
        if ({led, cfg_ready, cfg_err} !== 5'b0) begin
          n_fail++;
          $display("[TB] FAIL reset_state cyc %0d: got led=%b rdy=%b err=%b, want all 0", cyc, led, cfg_ready, cfg_err);
        end
      end else begin
        n_checks++;
        if (dut.u_tick.tick !== ((k - 3) % 4 == 2)) begin
          n_fail++;
          $display("[TB] FAIL tick_period cyc %0d: got tick=%b, want %b", cyc, dut.u_tick.tick, ((k - 3) % 4 == 2));
        end
        n_checks++;
        if (cfg_ready !== 1'b1 || led !== 3'b000) begin
          n_fail++;
          $display("[TB] FAIL idle_after_reset cyc %0d: got rdy=%b led=%b, want rdy=1 led=000", cyc, cfg_ready, led);
        end
      end
    end
  endtask

  task automatic test_on();
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, k == 1, 2'd0, ON, 3'd0, 8'd0);
      e = sb.pop_front();
      n_checks++;
      if ({led, cfg_ready, cfg_err, dut.u_tick.tick} !== e) begin
        n_fail++;
        $display("[TB] FAIL on_sb cyc %0d: got led=%b rdy=%b err=%b tick=%b, want led=%b rdy=%b err=%b tick=%b",
                 cyc, led, cfg_ready, cfg_err, dut.u_tick.tick, e.led, e.ready, e.err, e.tick);
      end
      if (k == 1 || k == 2) begin
        n_checks++;
        if (led[0] !== (k == 2)) begin
          n_fail++;
          $display("[TB] FAIL on_latency cyc %0d: got led0=%b, want %b", cyc, led[0], (k == 2));
        end
      end
    end
  endtask

  task automatic test_blink(input logic [2:0] rate);
    exp_t e;
    int   trans[$];
    int   per;
    int   n;
    logic prev;
    per  = TICK_DIV << rate;
    n    = 3 + 4 * per + 8;
    prev = 1'b0;
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, k == 2, 2'd1, BLINK, rate, 8'd0);
      e = sb.pop_front();
      n_checks++;
      if ({led, cfg_ready, cfg_err, dut.u_tick.tick} !== e) begin
        n_fail++;
        $display("[TB] FAIL blink_sb cyc %0d: got led=%b rdy=%b err=%b tick=%b, want led=%b rdy=%b err=%b tick=%b",
                 cyc, led, cfg_ready, cfg_err, dut.u_tick.tick, e.led, e.ready, e.err, e.tick);
      end
      if (k == 3) begin
        n_checks++;
        if (led[1] !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL blink_starts_low rate %0d: got led1=%b, want 0", rate, led[1]);
        end
        prev = led[1];
      end else if (k > 3) begin
        if (led[1] !== prev) trans.push_back(k);
        prev = led[1];
      end
    end
    n_checks++;
    if (trans.size() < 3) begin
      n_fail++;
      $display("[TB] FAIL blink_toggles rate %0d: got %0d transitions, want at least 3", rate, trans.size());
    end else begin
      n_checks++;
      if (trans[1] - trans[0] !== per || trans[2] - trans[1] !== per) begin
        n_fail++;
        $display("[TB] FAIL blink_half_period rate %0d: got %0d/%0d clk, want %0d", rate,
                 trans[1] - trans[0], trans[2] - trans[1], per);
      end
    end
  endtask

  task automatic test_pwm(input logic [7:0] duty, input int exp_high);
    exp_t e;
    int   high;
    high = 0;
    for (int k = 0; k < 1026; k++) begin
      applyStimulus(1'b0, k == 1, 2'd2, PWM, 3'd0, duty);
      e = sb.pop_front();
      n_checks++;
      if ({led, cfg_ready, cfg_err, dut.u_tick.tick} !== e) begin
        n_fail++;
        $display("[TB] FAIL pwm_sb cyc %0d: got led=%b rdy=%b err=%b tick=%b, want led=%b rdy=%b err=%b tick=%b",
                 cyc, led, cfg_ready, cfg_err, dut.u_tick.tick, e.led, e.ready, e.err, e.tick);
      end
      if (k >= 2 && led[2] === 1'b1) high++;
    end
    n_checks++;
    if (high !== exp_high) begin
      n_fail++;
      $display("[TB] FAIL pwm_high_count duty %0d: got %0d clk high, want %0d", duty, high, exp_high);
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [5:0] rd;
    logic [1:0] mds [6];
    int         acc;
    mds = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd0};
    acc = 0;
    rd  = '0;
    for (int k = 0; k < 10; k++) begin
      if (k >= 2 && k < 8) begin
        rd[7 - k] = cfg_ready;
        if (cfg_ready === 1'b1) acc++;
      end
      applyStimulus(1'b0, (k >= 2 && k < 8), 2'd0, (k >= 2 && k < 8) ? mds[(k >= 2 && k < 8) ? k - 2 : 0] : 2'd0,
                    3'd1, 8'd10);
      e = sb.pop_front();
      n_checks++;
      if ({led, cfg_ready, cfg_err, dut.u_tick.tick} !== e) begin
        n_fail++;
        $display("[TB] FAIL b2b_sb cyc %0d: got led=%b rdy=%b err=%b tick=%b, want led=%b rdy=%b err=%b tick=%b",
                 cyc, led, cfg_ready, cfg_err, dut.u_tick.tick, e.led, e.ready, e.err, e.tick);
      end
    end
    n_checks++;
    if (rd !== 6'b101010) begin
      n_fail++;
      $display("[TB] FAIL b2b_ready_pattern: got %b, want 101010", rd);
    end
    n_checks++;
    if (acc !== 3) begin
      n_fail++;
      $display("[TB] FAIL b2b_accept_count: got %0d, want 3", acc);
    end
    n_checks++;
    if (led[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_last_write: got led0=%b, want 1", led[0]);
    end
  endtask

  task automatic test_bad_channel();
    exp_t e;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, k == 2, 2'd3, OFF, 3'd0, 8'd0);
      e = sb.pop_front();
      n_checks++;
      if ({led, cfg_ready, cfg_err, dut.u_tick.tick} !== e) begin
        n_fail++;
        $display("[TB] FAIL badch_sb cyc %0d: got led=%b rdy=%b err=%b tick=%b, want led=%b rdy=%b err=%b tick=%b",
                 cyc, led, cfg_ready, cfg_err, dut.u_tick.tick, e.led, e.ready, e.err, e.tick);
      end
      if (k >= 1 && k <= 4) begin
        n_checks++;
        if (cfg_err !== (k == 2)) begin
          n_fail++;
          $display("[TB] FAIL badch_err_pulse cyc %0d: got err=%b, want %b", cyc, cfg_err, (k == 2));
        end
      end
    end
  endtask

  task automatic test_write_on_tick();
    exp_t e;
    logic found;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 8'd0);
      e = sb.pop_front();
      n_checks++;
      if ({led, cfg_ready, cfg_err, dut.u_tick.tick} !== e) begin
        n_fail++;
        $display("[TB] FAIL wtick_sb cyc %0d: got led=%b rdy=%b err=%b tick=%b, want led=%b rdy=%b err=%b tick=%b",
                 cyc, led, cfg_ready, cfg_err, dut.u_tick.tick, e.led, e.ready, e.err, e.tick);
      end
      if (m_cnt == TICK_DIV - 1 && m_ready) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL wtick_align: got no ready tick cycle within 8, want one");
    end else begin
      for (int j = 0; j < 7; j++) begin
        applyStimulus(1'b0, j == 0, 2'd2, BLINK, 3'd0, 8'd0);
        e = sb.pop_front();
        n_checks++;
        if ({led, cfg_ready, cfg_err, dut.u_tick.tick} !== e) begin
          n_fail++;
          $display("[TB] FAIL wtick_sb cyc %0d: got led=%b rdy=%b err=%b tick=%b, want led=%b rdy=%b err=%b tick=%b",
                   cyc, led, cfg_ready, cfg_err, dut.u_tick.tick, e.led, e.ready, e.err, e.tick);
        end
        if (j >= 1 && j <= 5) begin
          n_checks++;
          if (led[2] !== (j == 5)) begin
            n_fail++;
            $display("[TB] FAIL wtick_phase_cleared sample %0d: got led2=%b, want %b", j, led[2], (j == 5));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int k = 0; k < 11; k++) begin
      applyStimulus(k == 2, k == 2, 2'd0, ON, 3'd0, 8'd0);
      e = sb.pop_front();
      n_checks++;
      if ({led, cfg_ready, cfg_err, dut.u_tick.tick} !== e) begin
        n_fail++;
        $display("[TB] FAIL rstmid_sb cyc %0d: got led=%b rdy=%b err=%b tick=%b, want led=%b rdy=%b err=%b tick=%b",
                 cyc, led, cfg_ready, cfg_err, dut.u_tick.tick, e.led, e.ready, e.err, e.tick);
      end
      if (k == 2) begin
        n_checks++;
        if ({led, cfg_ready, cfg_err} !== 5'b0) begin
          n_fail++;
          $display("[TB] FAIL rstmid_clear: got led=%b rdy=%b err=%b, want all 0", led, cfg_ready, cfg_err);
        end
      end else if (k > 2) begin
        n_checks++;
        if (led !== 3'b000 || cfg_ready !== (k != 3 || 1'b1)) begin
          n_fail++;
          $display("[TB] FAIL rstmid_write_dropped cyc %0d: got led=%b rdy=%b, want led=000 rdy=1", cyc, led, cfg_ready);
        end
      end
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got no finish by 1ms, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_phase[i] = '0;
      m_mode[i]  = '0;
      m_rate[i]  = '0;
      m_duty[i]  = '0;
    end
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = '0;
    cfg_rate  = '0;
    cfg_duty  = '0;
    $display("[TB] starting led_blinker bench");
    test_reset();
    test_on();
    test_blink(3'd0);
    test_blink(3'd2);
    test_pwm(8'd64, 64 * TICK_DIV);
    test_pwm(8'd0, 0);
    test_pwm(8'd255, 255 * TICK_DIV);
    test_back_to_back();
    test_bad_channel();
    test_write_on_tick();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
